// File: rtl/spi_ram_ctrl.sv
// SPI-side RAM controller: decodes 2-bit commands, sequences address/data, returns reads.
// Optional SPI_RAM_AUTOINC_EN: post-increment wr/rd address after accepted data commands.
module spi_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ARM = 2'd1,
    RD_ARM = 2'd2
  } state_e;

  localparam logic [1:0] CMD_WA = 2'b00;
  localparam logic [1:0] CMD_WD = 2'b01;
  localparam logic [1:0] CMD_RA = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(MEM_DEPTH);

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    ADDR_WIDTH'(MEM_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a == LAST_A) ? '0 : a + 1'b1;
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  mem_we;

  logic [1:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] payload;
  logic                  wr_oor;
  logic                  rd_oor;
  logic                  slot_free;

  assign cmd       = din[DATA_WIDTH+1:DATA_WIDTH];
  assign addr      = din[ADDR_WIDTH-1:0];
  assign payload   = din[DATA_WIDTH-1:0];
  assign wr_oor    = {1'b0, wr_addr_q} >= DEPTH_W;
  assign rd_oor    = {1'b0, rd_addr_q} >= DEPTH_W;
  assign slot_free = ~tx_valid_q | tx_ready;

  // Command decode, FSM next state and tx handshake.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q & ~tx_ready;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WA: begin
          wr_addr_d = addr;
          state_d   = WR_ARM;
        end
        CMD_WD: begin
          if (state_q != WR_ARM || wr_oor) begin
            cmd_err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end
        end
        CMD_RA: begin
          rd_addr_d = addr;
          state_d   = RD_ARM;
        end
        CMD_RD: begin
          if (state_q != RD_ARM || !slot_free) begin
            cmd_err_d = 1'b1;
          end else if (rd_oor) begin
            dout_d     = '0;
            tx_valid_d = 1'b1;
            cmd_err_d  = 1'b1;
          end else begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = next_addr(rd_addr_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers; memory array is left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Single write port into the array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload;
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: default instance plus a MEM_DEPTH=200 instance.
// Expected values are hand-computed; autoinc expectations follow SPI_RAM_AUTOINC_EN.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;
  logic [7:0] dout2;
  logic       tx_valid2;
  logic       cmd_err2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200)) u_dut200 (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .dout     (dout2),
    .tx_valid (tx_valid2),
    .cmd_err  (cmd_err2)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] c,
                      input logic [7:0] pl,
                      input logic rdy);
    din      = {c, pl};
    rx_valid = 1'b1;
    tx_ready = rdy;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    rx_valid = 1'b0;
    tx_ready = rdy;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_txv", 8'(tx_valid), 8'h0);
    check("rst_err", 8'(cmd_err), 8'h0);
    rst = 1'b0;
    idle(1'b0);

    // basic write then read, held until consumed
    send(2'b00, 8'h12, 1'b0);
    send(2'b01, 8'hA5, 1'b0);
    check("t2_wr_err", 8'(cmd_err), 8'h0);
    send(2'b10, 8'h12, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t2_txv", 8'(tx_valid), 8'h1);
    check("t2_dout", dout, 8'hA5);
    idle(1'b0);
    check("t2_hold_txv", 8'(tx_valid), 8'h1);
    check("t2_hold_dout", dout, 8'hA5);
    idle(1'b1);
    check("t2_ack_txv", 8'(tx_valid), 8'h0);
    check("t2_ack_dout", dout, 8'hA5);

    // known word at address 0, read pending, then async reset
    send(2'b00, 8'h00, 1'b0);
    send(2'b01, 8'h3C, 1'b0);
    send(2'b10, 8'h00, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t1_pre_txv", 8'(tx_valid), 8'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_txv", 8'(tx_valid), 8'h0);
    check("t1_dout", dout, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(2'b11, 8'h00, 1'b0);
    check("t1_idle_err", 8'(cmd_err), 8'h1);
    check("t1_idle_txv", 8'(tx_valid), 8'h0);
    idle(1'b0);
    check("t1_err_pulse", 8'(cmd_err), 8'h0);

    // data write with no address armed is rejected
    send(2'b01, 8'h55, 1'b0);
    check("t3_err", 8'(cmd_err), 8'h1);
    check("t3_txv", 8'(tx_valid), 8'h0);
    send(2'b10, 8'h00, 1'b0);
    check("t3_err_clr", 8'(cmd_err), 8'h0);
    send(2'b11, 8'h00, 1'b0);
    check("t3_nowrite", dout, 8'h3C);
    idle(1'b1);

    // busy slot rejects; same-edge ack accepts new data
    send(2'b00, 8'h20, 1'b0);
    send(2'b01, 8'h77, 1'b0);
    send(2'b00, 8'h21, 1'b0);
    send(2'b01, 8'h88, 1'b0);
    send(2'b10, 8'h20, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t4_first", dout, 8'h77);
    send(2'b10, 8'h21, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t4_busy_err", 8'(cmd_err), 8'h1);
    check("t4_busy_dout", dout, 8'h77);
    check("t4_busy_txv", 8'(tx_valid), 8'h1);
    send(2'b11, 8'h00, 1'b1);
    check("t4_swap_dout", dout, 8'h88);
    check("t4_swap_txv", 8'(tx_valid), 8'h1);
    check("t4_swap_err", 8'(cmd_err), 8'h0);
    idle(1'b1);
    check("t4_drain", 8'(tx_valid), 8'h0);

    // burst write across the top address
    send(2'b00, 8'hFF, 1'b0);
    send(2'b01, 8'h11, 1'b0);
    send(2'b01, 8'h22, 1'b0);
    send(2'b10, 8'hFF, 1'b0);
    send(2'b11, 8'h00, 1'b0);
`ifdef SPI_RAM_AUTOINC_EN
    check("t5_rd0", dout, 8'h11);
`else
    check("t5_rd0", dout, 8'h22);
`endif
    send(2'b11, 8'h00, 1'b1);
    check("t5_rd1", dout, 8'h22);
    idle(1'b1);
    send(2'b10, 8'h00, 1'b0);
    send(2'b11, 8'h00, 1'b0);
`ifdef SPI_RAM_AUTOINC_EN
    check("t5_wrap", dout, 8'h22);
`else
    check("t5_wrap", dout, 8'h3C);
`endif
    idle(1'b1);

    // depth-200 instance: last legal word, then out-of-range
    send(2'b00, 8'hC7, 1'b0);
    send(2'b01, 8'h5A, 1'b0);
    check("t6_lastwr_err", 8'(cmd_err2), 8'h0);
    send(2'b10, 8'hC7, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t6_last_dout", dout2, 8'h5A);
    check("t6_last_err", 8'(cmd_err2), 8'h0);
    idle(1'b1);
    send(2'b00, 8'hC8, 1'b0);
    send(2'b01, 8'h99, 1'b0);
    check("t6_oorwr_err", 8'(cmd_err2), 8'h1);
    check("t6_full_wr_err", 8'(cmd_err), 8'h0);
    send(2'b10, 8'hC8, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check("t6_oor_dout", dout2, 8'h00);
    check("t6_oor_txv", 8'(tx_valid2), 8'h1);
    check("t6_oor_err", 8'(cmd_err2), 8'h1);
    check("t6_full_rd_err", 8'(cmd_err), 8'h0);
    idle(1'b1);
    check("t6_oor_pulse", 8'(cmd_err2), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
